md_timestep_sequencer: RTL

Top-level phase scheduler for the MD timestep loop. It runs the force pipeline, the velocity update and the position update controllers in order, each for one full pass per timestep, and owns the double-buffer select shared by all three. It repeats this for a programmed number of timesteps, then reports completion to the host interface. It sits above the three phase controllers and drives their ready/double_buffer inputs.

---
 rtl/md_ctrl_pkg.sv | 23 ++
 rtl/md_timestep_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the MD timestep sequencer and the phase controllers it drives.
// Sequencer state encoding, default step-count width and buffer geometry.
package md_ctrl_pkg;

    localparam int unsigned STEPW_DEFAULT = 32;
    // Number of halves selected by double_buffer.
    localparam int unsigned DBSIZE        = 2;

    localparam logic [2:0] SEQ_IDLE  = 3'd0;
    localparam logic [2:0] SEQ_FORCE = 3'd1;
    localparam logic [2:0] SEQ_FGAP  = 3'd2;
    localparam logic [2:0] SEQ_VEL   = 3'd3;
    localparam logic [2:0] SEQ_VGAP  = 3'd4;
    localparam logic [2:0] SEQ_POS   = 3'd5;
    localparam logic [2:0] SEQ_SWAP  = 3'd6;
    localparam logic [2:0] SEQ_FIN   = 3'd7;

    // States in which an abort cancels the run.
    function automatic logic seq_abortable(input logic [2:0] st);
        return (st != SEQ_IDLE) && (st != SEQ_FIN);
    endfunction

endpackage

// File: rtl/md_timestep_sequencer.sv
// Phase scheduler for the MD timestep loop: force -> velocity -> position per step,
// flipping the shared double-buffer select after each completed step.
module md_timestep_sequencer
    import md_ctrl_pkg::*;
#(
    parameter int unsigned STEPW      = STEPW_DEFAULT,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [STEPW-1:0] num_steps,
    input  logic             abort,
    output logic             force_ready,
    input  logic             force_done,
    output logic             vel_ready,
    input  logic             vel_done,
    output logic             pos_ready,
    input  logic             pos_done,
    output logic             double_buffer,
    output logic [STEPW-1:0] step_count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int unsigned GAPW = $clog2(GAP_CYCLES + 1) + 1;

    logic [2:0]       state_q, state_d;
    logic [GAPW-1:0]  gap_q, gap_d;
    logic [STEPW-1:0] steps_q, steps_d;
    logic [STEPW-1:0] step_q, step_d;
    logic             db_q, db_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             gap_over;
    logic [STEPW-1:0] step_inc;

    // Gap counter runs 0..GAP_CYCLES, so every phase sees its ready low long enough to
    // reinitialise and drop a level-held done.
    assign gap_over = (gap_q == GAPW'(GAP_CYCLES));
    assign step_inc = step_q + STEPW'(1);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        steps_d   = steps_q;
        step_d    = step_q;
        db_d      = db_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (abort && seq_abortable(state_q)) begin
            state_d   = SEQ_IDLE;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start) begin
                        steps_d = num_steps;
                        step_d  = '0;
                        busy_d  = 1'b1;
                        state_d = (num_steps == '0) ? SEQ_FIN : SEQ_FORCE;
                    end
                end
                SEQ_FORCE: begin
                    if (force_done) begin
                        state_d = SEQ_FGAP;
                        gap_d   = '0;
                    end
                end
                SEQ_FGAP: begin
                    if (gap_over) begin
                        state_d = SEQ_VEL;
                    end else begin
                        gap_d = gap_q + GAPW'(1);
                    end
                end
                SEQ_VEL: begin
                    if (vel_done) begin
                        state_d = SEQ_VGAP;
                        gap_d   = '0;
                    end
                end
                SEQ_VGAP: begin
                    if (gap_over) begin
                        state_d = SEQ_POS;
                    end else begin
                        gap_d = gap_q + GAPW'(1);
                    end
                end
                SEQ_POS: begin
                    if (pos_done) begin
                        state_d = SEQ_SWAP;
                    end
                end
                SEQ_SWAP: begin
                    db_d    = ~db_q;
                    step_d  = step_inc;
                    state_d = (step_inc == steps_q) ? SEQ_FIN : SEQ_FORCE;
                end
                SEQ_FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = SEQ_IDLE;
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= SEQ_IDLE;
            gap_q     <= '0;
            steps_q   <= '0;
            step_q    <= '0;
            db_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            steps_q   <= steps_d;
            step_q    <= step_d;
            db_q      <= db_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign force_ready   = (state_q == SEQ_FORCE);
    assign vel_ready     = (state_q == SEQ_VEL);
    assign pos_ready     = (state_q == SEQ_POS);
    assign double_buffer = db_q;
    assign step_count    = step_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;

endmodule
